muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO result registers.
// One shift-add or restoring-divide step per clock, sign fix-up in a final cycle.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

    logic [1:0]          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic                b_zero_q, b_zero_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic                dz_q, dz_d;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] prod_fixed;
    logic                op_signed;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x,
                                                    input logic is_signed);
        return (is_signed && x[DATA_W-1]) ? ('0 - x) : x;
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                   input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_neg_wide(input logic [2*DATA_W-1:0] x,
                                                          input logic neg);
        return neg ? ('0 - x) : x;
    endfunction

    // prod_q holds {accumulator, multiplier} for MULT and {remainder, quotient} for DIV.
    assign mul_sum    = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + {1'b0, opb_q & {DATA_W{prod_q[0]}}};
    assign mul_next   = {mul_sum, prod_q[DATA_W-1:1]};
    assign div_shift  = prod_q[2*DATA_W-1:DATA_W-1];
    assign div_diff   = div_shift - {1'b0, opb_q};
    assign div_next   = div_diff[DATA_W]
                      ? {div_shift[DATA_W-1:0], prod_q[DATA_W-2:0], 1'b0}
                      : {div_diff[DATA_W-1:0],  prod_q[DATA_W-2:0], 1'b1};
    assign prod_fixed = cond_neg_wide(prod_q, sign_a_q ^ sign_b_q);
    assign op_signed  = ~op[0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = op_signed & a[DATA_W-1];
                    sign_b_d = op_signed & b[DATA_W-1];
                    b_zero_d = (b == '0);
                    opb_d    = magnitude(b, op_signed);
                    prod_d   = {{DATA_W{1'b0}}, magnitude(a, op_signed)};
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                prod_d = op_q[1] ? div_next : mul_next;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    // Divide by zero leaves the dividend magnitude in the remainder,
                    // so the dividend-sign fix-up alone restores the original a.
                    lo_d = b_zero_q ? '1 : cond_neg(prod_q[DATA_W-1:0], sign_a_q ^ sign_b_q);
                    hi_d = cond_neg(prod_q[2*DATA_W-1:DATA_W], sign_a_q);
                    dz_d = b_zero_q;
                end else begin
                    hi_d = prod_fixed[2*DATA_W-1:DATA_W];
                    lo_d = prod_fixed[DATA_W-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            opb_q    <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: MIPS-style HI/LO results from ordinary integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                                  output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        sa  = xa;
        sb  = xb;
        mdz = 1'b0;
        mh  = '0;
        ml  = '0;
        case (o)
            2'd0: begin
                sp = longint'(sa) * longint'(sb);
                up = sp;
                mh = up[63:32];
                ml = up[31:0];
            end
            2'd1: begin
                up = {32'd0, xa} * {32'd0, xb};
                mh = up[63:32];
                ml = up[31:0];
            end
            2'd2: begin
                if (xb == 0) begin
                    mh = xa; ml = 32'hFFFF_FFFF; mdz = 1'b1;
                end else if (xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) begin
                    mh = 32'd0; ml = 32'h8000_0000;
                end else begin
                    ml = sa / sb;
                    mh = sa % sb;
                end
            end
            default: begin
                if (xb == 0) begin
                    mh = xa; ml = 32'hFFFF_FFFF; mdz = 1'b1;
                end else begin
                    ml = xa / xb;
                    mh = xa % xb;
                end
            end
        endcase
    endfunction

    // Issues one operation and measures edges from the start edge to the done cycle.
    // stray flags any div_by_zero outside the done cycle or a done lasting past one cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                          output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdz, output logic stray);
        @(negedge clk);
        op = o; a = xa; b = xb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        stray = 1'b0;
        while (done !== 1'b1 && lat < 60) begin
            if (div_by_zero !== 1'b0) stray = 1'b1;
            @(negedge clk);
            lat++;
        end
        rhi = hi;
        rlo = lo;
        rdz = div_by_zero;
        @(negedge clk);
        if (done !== 1'b0 || div_by_zero !== 1'b0) stray = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dz got=%b want=0", div_by_zero); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL reset_hi got=%h want=0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL reset_lo got=%h want=0", lo); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [5]  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        logic [31:0] as  [5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [31:0] bs  [5]  = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ehs [5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'h0000_0064};
        logic [31:0] els [5]  = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
        logic        edz [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          lat;
        logic [31:0] rh, rl;
        logic        rdz, stray;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], lat, rh, rl, rdz, stray);
            n_checks++; if (lat != 33) $display("FAIL dir%0d_latency got=%0d want=33", i, lat); else n_pass++;
            n_checks++; if (rh !== ehs[i]) $display("FAIL dir%0d_hi got=%h want=%h", i, rh, ehs[i]); else n_pass++;
            n_checks++; if (rl !== els[i]) $display("FAIL dir%0d_lo got=%h want=%h", i, rl, els[i]); else n_pass++;
            n_checks++; if (rdz !== edz[i]) $display("FAIL dir%0d_dz got=%b want=%b", i, rdz, edz[i]); else n_pass++;
            n_checks++; if (stray !== 1'b0) $display("FAIL dir%0d_stray_pulse got=%b want=0", i, stray); else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] xa, xb, mh, ml, rh, rl;
        logic        mdz, rdz, stray;
        int          lat, sel;
        for (int i = 0; i < 24; i++) begin
            o   = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            xa  = (sel == 1) ? 32'h8000_0000 : $urandom;
            case (sel)
                0:       xb = 32'd0;
                2:       xb = $urandom_range(1, 20);
                3:       xb = 32'hFFFF_FFFF;
                default: xb = $urandom;
            endcase
            model(o, xa, xb, mh, ml, mdz);
            run_op(o, xa, xb, lat, rh, rl, rdz, stray);
            n_checks++; if (lat != 33) $display("FAIL rnd%0d_latency got=%0d want=33", i, lat); else n_pass++;
            n_checks++; if (rh !== mh) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, o, xa, xb, rh, mh); else n_pass++;
            n_checks++; if (rl !== ml) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, o, xa, xb, rl, ml); else n_pass++;
            n_checks++; if (rdz !== mdz || stray !== 1'b0) $display("FAIL rnd%0d_dz got=%b/%b want=%b/0", i, rdz, stray, mdz); else n_pass++;
        end
    endtask

    task automatic test_mthi_mtlo;
        int cyc;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        n_checks++; if (hi !== 32'h1234_5678) $display("FAIL mthi got=%h want=12345678", hi); else n_pass++;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++; if (lo !== 32'h9ABC_DEF0) $display("FAIL mtlo got=%h want=9abcdef0", lo); else n_pass++;
        n_checks++; if (hi !== 32'h1234_5678) $display("FAIL mtlo_keeps_hi got=%h want=12345678", hi); else n_pass++;
        // Writes coinciding with start must be dropped.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        n_checks++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0)
            $display("FAIL mt_with_start_dropped got=%h/%h want=12345678/9abcdef0", hi, lo); else n_pass++;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        n_checks++; if (cyc != 33 || hi !== 32'd0 || lo !== 32'd42)
            $display("FAIL mt_then_result lat=%0d hi=%h lo=%h want 33/0/2a", cyc, hi, lo); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] mh, ml, hold_hi, hold_lo;
        logic        mdz, held;
        int          cyc;
        @(negedge clk);
        hold_hi = hi; hold_lo = lo;
        op = 2'd1; a = 32'd7; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 0; held = 1'b1;
        while (done !== 1'b1 && cyc < 60) begin
            if (hi !== hold_hi || lo !== hold_lo) held = 1'b0;
            if (cyc == 5) begin
                start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
                hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; hi_we = 1'b0;
        n_checks++; if (held !== 1'b1) $display("FAIL b2b_hold_during_run got=%b want=1", held); else n_pass++;
        n_checks++; if (cyc != 33) $display("FAIL b2b_first_latency got=%0d want=33", cyc); else n_pass++;
        n_checks++; if (hi !== 32'd0 || lo !== 32'd63) $display("FAIL b2b_first_result got=%h/%h want=0/3f", hi, lo); else n_pass++;
        // New start in the done cycle.
        op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_start_in_done got=%b want=1", busy); else n_pass++;
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        model(2'd3, 32'd100, 32'd7, mh, ml, mdz);
        n_checks++; if (cyc != 33) $display("FAIL b2b_second_latency got=%0d want=33", cyc); else n_pass++;
        n_checks++; if (hi !== mh || lo !== ml) $display("FAIL b2b_second_result got=%h/%h want=%h/%h", hi, lo, mh, ml); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [31:0] mh, ml, rh, rl;
        logic        mdz, rdz, stray, seen;
        int          lat;
        run_op(2'd1, 32'h0001_0001, 32'h0001_0001, lat, rh, rl, rdz, stray);
        @(negedge clk);
        op = 2'd2; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || hi !== 32'd1 || lo !== 32'h0002_0001)
            $display("FAIL abort_pre busy=%b hi=%h lo=%h want 1/1/20001", busy, hi, lo); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL abort_hilo got=%h/%h want=0/0", hi, lo); else n_pass++;
        seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_done got=%b want=0", seen); else n_pass++;
        model(2'd2, 32'hFFFF_FF9C, 32'd7, mh, ml, mdz);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd7, lat, rh, rl, rdz, stray);
        n_checks++; if (lat != 33 || rh !== mh || rl !== ml || rdz !== mdz || stray !== 1'b0)
            $display("FAIL after_reset_op lat=%0d got=%h/%h want=%h/%h", lat, rh, rl, mh, ml); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
